// File: rtl/regfile_ctrl_pkg.sv
// Shared sizes and FSM state type for the register-file write-port controller.
package regfile_ctrl_pkg;
  localparam int ADDR_W = 3;
  localparam int DATA_W = 16;
  localparam int NREGS  = 2 ** ADDR_W;

  typedef enum logic {ARB, CLEAR} wr_state_t;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin grant: first valid requester at or after ptr, wrapping.
module rr_arbiter #(
  parameter  int NREQ = 2,
  localparam int ID_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req_valid,
  input  logic [ID_W-1:0] ptr,
  output logic [NREQ-1:0] grant,
  output logic [ID_W-1:0] grant_id
);
  int   idx;
  logic found;

  always_comb begin
    grant    = '0;
    grant_id = ptr;
    found    = 1'b0;
    idx      = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!found && req_valid[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_id   = ID_W'(idx);
      end
    end
  end
endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin owner of the register file write port, with a clear sequencer
// and a read-after-write hazard flag for the datapath source reads.
module regfile_write_arbiter #(
  parameter  int NREQ   = 2,
  parameter  int ADDR_W = regfile_ctrl_pkg::ADDR_W,
  parameter  int DATA_W = regfile_ctrl_pkg::DATA_W,
  parameter  int NREGS  = regfile_ctrl_pkg::NREGS,
  localparam int ID_W   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*ADDR_W-1:0]   req_dr,
  input  logic [NREQ*DATA_W-1:0]   req_data,
  output logic [NREQ-1:0]          req_ready,
  input  logic                     clr_start,
  output logic                     clr_busy,
  input  logic [ADDR_W-1:0]        SR1_in,
  input  logic [ADDR_W-1:0]        SR2_in,
  output logic                     raw_hazard,
  output logic [ADDR_W-1:0]        DR,
  output logic [DATA_W-1:0]        D_in,
  output logic                     LD_REG,
  output logic [ID_W-1:0]          grant_id
);
  import regfile_ctrl_pkg::*;

  localparam int CNT_W = (NREGS > 1) ? $clog2(NREGS) : 1;

  wr_state_t          state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [ID_W-1:0]    ptr, ptr_nxt;
  logic [NREQ-1:0]    grant;
  logic [ID_W-1:0]    arb_id;
  logic               arb_en, xfer;
  logic               ld_nxt;
  logic [ADDR_W-1:0]  dr_nxt;
  logic [DATA_W-1:0]  din_nxt;
  logic [ID_W-1:0]    gid_nxt;

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .req_valid (req_valid),
    .ptr       (ptr),
    .grant     (grant),
    .grant_id  (arb_id)
  );

  // A pending clear takes the port away from requesters in the same cycle.
  assign arb_en    = (state == ARB) && !clr_start;
  assign req_ready = Reset ? (grant & {NREQ{arb_en}}) : '0;
  assign xfer      = |(req_valid & req_ready);
  assign clr_busy  = (state == CLEAR);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ptr_nxt   = ptr;
    ld_nxt    = 1'b0;
    dr_nxt    = DR;
    din_nxt   = D_in;
    gid_nxt   = grant_id;
    unique case (state)
      ARB: begin
        if (clr_start) begin
          state_nxt = CLEAR;
          cnt_nxt   = '0;
        end else if (xfer) begin
          ld_nxt  = 1'b1;
          dr_nxt  = req_dr[arb_id*ADDR_W +: ADDR_W];
          din_nxt = req_data[arb_id*DATA_W +: DATA_W];
          gid_nxt = arb_id;
          ptr_nxt = (int'(arb_id) == NREQ - 1) ? '0 : arb_id + 1'b1;
        end
      end
      CLEAR: begin
        ld_nxt  = 1'b1;
        dr_nxt  = ADDR_W'(cnt);
        din_nxt = '0;
        if (int'(cnt) == NREGS - 1) begin
          state_nxt = ARB;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: state_nxt = ARB;
    endcase
  end

  // Output stage: one registered write per cycle towards the register file.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state    <= ARB;
      cnt      <= '0;
      ptr      <= '0;
      LD_REG   <= 1'b0;
      DR       <= '0;
      D_in     <= '0;
      grant_id <= '0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      ptr      <= ptr_nxt;
      LD_REG   <= ld_nxt;
      DR       <= dr_nxt;
      D_in     <= din_nxt;
      grant_id <= gid_nxt;
    end
  end

  // The write lands at the end of this cycle, so same-cycle reads of DR are stale.
  assign raw_hazard = LD_REG && ((DR == SR1_in) || (DR == SR2_in));
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: arbitration, clear, hazard, reset abort.
module tb_regfile_write_arbiter;
  localparam int NREQ = 2, ADDR_W = 3, DATA_W = 16;

  logic                   Clk = 1'b0;
  logic                   Reset = 1'b0;
  logic [NREQ-1:0]        req_valid = '0;
  logic [NREQ*ADDR_W-1:0] req_dr = '0;
  logic [NREQ*DATA_W-1:0] req_data = '0;
  logic [NREQ-1:0]        req_ready;
  logic                   clr_start = 1'b0;
  logic                   clr_busy;
  logic [ADDR_W-1:0]      SR1_in = '0, SR2_in = '0;
  logic                   raw_hazard;
  logic [ADDR_W-1:0]      DR;
  logic [DATA_W-1:0]      D_in;
  logic                   LD_REG;
  logic [0:0]             grant_id;

  int errors = 0;
  int checks = 0;

  regfile_write_arbiter #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NREGS(8)) dut (
    .Clk(Clk), .Reset(Reset), .req_valid(req_valid), .req_dr(req_dr), .req_data(req_data),
    .req_ready(req_ready), .clr_start(clr_start), .clr_busy(clr_busy), .SR1_in(SR1_in),
    .SR2_in(SR2_in), .raw_hazard(raw_hazard), .DR(DR), .D_in(D_in), .LD_REG(LD_REG),
    .grant_id(grant_id)
  );

  always #5 Clk = ~Clk;

  // Advance to just after the next rising edge; inputs set afterwards apply to this cycle.
  task automatic step();
    @(posedge Clk);
    #2;
  endtask

  task automatic do_reset();
    Reset = 1'b0; req_valid = '0; clr_start = 1'b0;
    step(); step();
    Reset = 1'b1;
  endtask

  task automatic test_reset();
    Reset = 1'b0; req_valid = 2'b11; clr_start = 1'b0;
    step(); step(); #1;
    checks++; if (LD_REG !== 1'b0) begin errors++; $display("FAIL reset_ld got=%b exp=0", LD_REG); end
    checks++; if (DR !== 3'd0) begin errors++; $display("FAIL reset_dr got=%0d exp=0", DR); end
    checks++; if (D_in !== 16'h0) begin errors++; $display("FAIL reset_din got=%h exp=0000", D_in); end
    checks++; if (grant_id !== 1'b0) begin errors++; $display("FAIL reset_gid got=%b exp=0", grant_id); end
    checks++; if (clr_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", clr_busy); end
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_ready got=%b exp=00", req_ready); end
    req_valid = '0; Reset = 1'b1;
    step();
  endtask

  task automatic test_single();
    req_valid = 2'b01; req_dr[2:0] = 3'd3; req_data[15:0] = 16'h1234; #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL single_ready got=%b exp=01", req_ready); end
    step(); req_valid = '0; #1;
    checks++; if (LD_REG !== 1'b1 || DR !== 3'd3 || D_in !== 16'h1234 || grant_id !== 1'b0) begin
      errors++; $display("FAIL single_write got ld=%b dr=%0d din=%h gid=%b exp ld=1 dr=3 din=1234 gid=0", LD_REG, DR, D_in, grant_id); end
    step(); #1;
    checks++; if (LD_REG !== 1'b0 || DR !== 3'd3) begin
      errors++; $display("FAIL single_idle got ld=%b dr=%0d exp ld=0 dr=3", LD_REG, DR); end
  endtask

  task automatic test_alternate();
    do_reset();
    req_dr = {3'd2, 3'd1}; req_data = {16'hB002, 16'hA001}; req_valid = 2'b11;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (req_ready !== ((i % 2 == 0) ? 2'b01 : 2'b10)) begin
        errors++; $display("FAIL alt_ready[%0d] got=%b exp=%b", i, req_ready, (i % 2 == 0) ? 2'b01 : 2'b10); end
      step(); #1;
      checks++; if (LD_REG !== 1'b1 || grant_id !== 1'(i % 2) ||
                    D_in !== ((i % 2 == 0) ? 16'hA001 : 16'hB002) || DR !== ((i % 2 == 0) ? 3'd1 : 3'd2)) begin
        errors++; $display("FAIL alt_write[%0d] got ld=%b gid=%b dr=%0d din=%h", i, LD_REG, grant_id, DR, D_in); end
    end
  endtask

  task automatic test_clear();
    req_valid = 2'b10; req_dr[5:3] = 3'd6; req_data[31:16] = 16'hC0DE; clr_start = 1'b1; #1;
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL clr_ready_t got=%b exp=00", req_ready); end
    for (int k = 1; k <= 9; k++) begin
      step(); clr_start = 1'b0; #1;
      checks++; if (clr_busy !== (k <= 8)) begin
        errors++; $display("FAIL clr_busy[t+%0d] got=%b exp=%b", k, clr_busy, (k <= 8)); end
      if (k >= 2) begin
        checks++; if (LD_REG !== 1'b1 || DR !== 3'(k - 2) || D_in !== 16'h0) begin
          errors++; $display("FAIL clr_write[t+%0d] got ld=%b dr=%0d din=%h exp ld=1 dr=%0d din=0000", k, LD_REG, DR, D_in, k - 2); end
      end
      checks++; if (req_ready !== ((k == 9) ? 2'b10 : 2'b00)) begin
        errors++; $display("FAIL clr_grant[t+%0d] got=%b", k, req_ready); end
    end
    step(); req_valid = '0; #1;
    checks++; if (LD_REG !== 1'b1 || grant_id !== 1'b1 || DR !== 3'd6 || D_in !== 16'hC0DE) begin
      errors++; $display("FAIL clr_after got ld=%b gid=%b dr=%0d din=%h exp ld=1 gid=1 dr=6 din=c0de", LD_REG, grant_id, DR, D_in); end
    step();
  endtask

  task automatic test_hazard();
    req_valid = 2'b01; req_dr[2:0] = 3'd5; req_data[15:0] = 16'h5555;
    step(); req_valid = '0;
    SR1_in = 3'd5; SR2_in = 3'd0; #1;
    checks++; if (raw_hazard !== 1'b1) begin errors++; $display("FAIL haz_sr1 got=%b exp=1", raw_hazard); end
    SR1_in = 3'd2; SR2_in = 3'd5; #1;
    checks++; if (raw_hazard !== 1'b1) begin errors++; $display("FAIL haz_sr2 got=%b exp=1", raw_hazard); end
    SR1_in = 3'd1; SR2_in = 3'd2; #1;
    checks++; if (raw_hazard !== 1'b0) begin errors++; $display("FAIL haz_none got=%b exp=0", raw_hazard); end
    step(); SR1_in = 3'd5; #1;
    checks++; if (raw_hazard !== 1'b0) begin errors++; $display("FAIL haz_idle got=%b exp=0", raw_hazard); end
    SR1_in = 3'd0;
  endtask

  task automatic test_reset_mid_clear();
    clr_start = 1'b1;
    step(); clr_start = 1'b0;
    step(); step(); step();
    Reset = 1'b0;
    step(); #1;
    checks++; if (clr_busy !== 1'b0 || LD_REG !== 1'b0) begin
      errors++; $display("FAIL midclr_abort got busy=%b ld=%b exp busy=0 ld=0", clr_busy, LD_REG); end
    Reset = 1'b1; req_valid = 2'b11; req_dr = {3'd4, 3'd7}; req_data = {16'h2222, 16'h1111}; #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL midclr_ptr got=%b exp=01", req_ready); end
    step(); req_valid = '0; #1;
    checks++; if (LD_REG !== 1'b1 || grant_id !== 1'b0 || DR !== 3'd7 || D_in !== 16'h1111) begin
      errors++; $display("FAIL midclr_write got ld=%b gid=%b dr=%0d din=%h", LD_REG, grant_id, DR, D_in); end
  endtask

  task automatic test_drop();
    req_valid = 2'b11; req_dr = {3'd4, 3'd6}; req_data = {16'hBEEF, 16'hDEAD}; #1;
    checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL drop_ready got=%b exp=10", req_ready); end
    step(); req_valid = '0; #1;
    checks++; if (LD_REG !== 1'b1 || grant_id !== 1'b1 || D_in !== 16'hBEEF) begin
      errors++; $display("FAIL drop_p1 got ld=%b gid=%b din=%h exp ld=1 gid=1 din=beef", LD_REG, grant_id, D_in); end
    for (int i = 0; i < 3; i++) begin
      step(); #1;
      checks++; if (LD_REG !== 1'b0 || D_in === 16'hDEAD) begin
        errors++; $display("FAIL drop_p0[%0d] got ld=%b din=%h exp ld=0 no dead", i, LD_REG, D_in); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_alternate();
    test_clear();
    test_hazard();
    test_reset_mid_clear();
    test_drop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
